// File: rtl/jt7759_seq_pkg.sv
// jt7759_seq_pkg
// Shared definitions for the JT7759 phrase sequencer: the FSM state type and
// the fixed tick counts used by the top level.
package jt7759_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAITB,
    ST_PLAY,
    ST_GAP,
    ST_STOP
  } state_t;

  localparam int STOP_TICKS = 4;   // cen ticks snd_rst is held high on a stop
  localparam int GAP_TICKS  = 1;   // cen ticks between busyn rising and the next pop
  localparam int TMO_TICKS  = 255; // cen ticks WAITB waits for busyn low

endpackage

// File: rtl/jt7759_seq_fifo.sv
// jt7759_seq_fifo
// Synchronous first-word-fall-through FIFO holding queued phrase numbers.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data; dropped (ovf pulse) when full
//                unless a pop happens in the same cycle
//   pop          read request; dout always shows the head entry
//   flush        empties the queue; wins over a simultaneous push
//   dout         head entry
//   level        number of stored entries (0..DEPTH)
//   full         level == DEPTH
//   ovf          registered one-cycle pulse for a dropped push
module jt7759_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && (level != '0) && !flush;
  // A pop frees a slot in the same cycle, so a push while full still fits.
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= push && !flush && full && !do_pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({do_push, do_pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jt7759_seq.sv
// jt7759_seq
// Phrase sequencer for the JT7759 ADPCM decoder in stand-alone mode. Play
// requests from the sound CPU are queued and started one at a time, each
// after the decoder reports the previous phrase finished via busyn.
// Ports:
//   clk, rst            sound CPU clock, asynchronous active-high reset
//   cen                 640 kHz clock enable shared with the decoder
//   req_we, req_phrase  push a phrase number into the queue
//   req_stop            abort playback and flush the queue
//   q_level             queued entries
//   ovf                 pulse when a push is dropped (queue full)
//   active              FSM not idle
//   err                 sticky busy-timeout flag
//   snd_rst/stn/cs/mdn/din  decoder chip interface, snd_busyn from decoder
// Optional feature: define JT7759_SEQ_TIMEOUT_EN to build the WAITB timeout
// and the err flag; otherwise WAITB waits forever and err is 0.
module jt7759_seq
  import jt7759_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   req_we,
  input  logic [7:0]             req_phrase,
  input  logic                   req_stop,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   ovf,
  output logic                   active,
  output logic                   err,
  output logic                   snd_rst,
  output logic                   snd_stn,
  output logic                   snd_cs,
  output logic                   snd_mdn,
  output logic [7:0]             snd_din,
  input  logic                   snd_busyn
);

  localparam int CNT_MAX = (STW > STOP_TICKS) ? STW : STOP_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    fifo_dout;
  logic          pop;

  // Stop has priority over everything, including the pop from IDLE.
  assign pop     = cen && !req_stop && (state == ST_IDLE) && (q_level != '0);
  assign snd_mdn = 1'b1;

`ifdef JT7759_SEQ_TIMEOUT_EN
  logic       fifo_full;
`endif

  jt7759_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_we),
    .din   (req_phrase),
    .pop   (pop),
    .flush (req_stop),
    .dout  (fifo_dout),
    .level (q_level),
`ifdef JT7759_SEQ_TIMEOUT_EN
    .full  (fifo_full),
`else
    .full  (),
`endif
    .ovf   (ovf)
  );

`ifdef JT7759_SEQ_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       push_ok;
  logic       tmo_hit;

  assign push_ok = req_we && !req_stop && (!fifo_full || pop);
  assign tmo_hit = cen && (state == ST_WAITB) && snd_busyn &&
                   (tmo_cnt == 8'(TMO_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state != ST_WAITB || req_stop) tmo_cnt <= '0;
      else if (cen)                      tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit && !req_stop) err <= 1'b1;
      else if (push_ok)         err <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      active  <= 1'b0;
      snd_rst <= 1'b1;
      snd_stn <= 1'b1;
      snd_cs  <= 1'b0;
      snd_din <= '0;
    end else begin
      // Decoder reset is only asserted while stopping; this also releases
      // it on the first edge after the sequencer reset goes away.
      snd_rst <= (state == ST_STOP);
      if (req_stop) begin
        state   <= ST_STOP;
        cnt     <= '0;
        active  <= 1'b1;
        snd_rst <= 1'b1;
        snd_stn <= 1'b1;
        snd_cs  <= 1'b0;
      end else if (cen) begin
        unique case (state)
          ST_IDLE: begin
            if (q_level != '0) begin
              snd_din <= fifo_dout;
              snd_cs  <= 1'b1;
              active  <= 1'b1;
              state   <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            snd_stn <= 1'b0;
            cnt     <= '0;
            state   <= ST_START;
          end
          ST_START: begin
            if (cnt == CW'(STW - 1)) begin
              snd_stn <= 1'b1;
              state   <= ST_WAITB;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_WAITB: begin
            if (!snd_busyn) state <= ST_PLAY;
`ifdef JT7759_SEQ_TIMEOUT_EN
            else if (tmo_hit) begin
              cnt   <= '0;
              state <= ST_GAP;
            end
`endif
          end
          ST_PLAY: begin
            if (snd_busyn) begin
              cnt   <= '0;
              state <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (cnt == CW'(GAP_TICKS - 1)) begin
              snd_cs <= 1'b0;
              active <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (cnt == CW'(STOP_TICKS - 1)) begin
              snd_rst <= 1'b0;
              active  <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              cnt     <= cnt + 1'b1;
              snd_rst <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt7759_seq.sv
// tb_jt7759_seq
// Self-checking bench for jt7759_seq (DEPTH=4, STW=2). A small decoder model
// answers each stn pulse with busyn low for a set number of cen ticks and logs
// the phrase, stn width and queue level seen at each start. Build with
// JT7759_SEQ_TIMEOUT_EN defined to also exercise the busy timeout.
`timescale 1ns/1ps
module tb_jt7759_seq;

  localparam int DEPTH = 4;
  localparam int STW   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_phrase = 8'h00;
  logic       req_stop = 1'b0;
  logic       snd_busyn = 1'b1;
  logic [2:0] q_level;
  logic       ovf, active, err, snd_rst, snd_stn, snd_cs, snd_mdn;
  logic [7:0] snd_din;

  int checks   = 0;
  int failures = 0;

  jt7759_seq #(.DEPTH(DEPTH), .STW(STW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .req_we     (req_we),
    .req_phrase (req_phrase),
    .req_stop   (req_stop),
    .q_level    (q_level),
    .ovf        (ovf),
    .active     (active),
    .err        (err),
    .snd_rst    (snd_rst),
    .snd_stn    (snd_stn),
    .snd_cs     (snd_cs),
    .snd_mdn    (snd_mdn),
    .snd_din    (snd_din),
    .snd_busyn  (snd_busyn)
  );

  always #5 clk = ~clk;

  // cen: one clk in four, updated just after the edge so it is stable at the
  // following edge.
  initial begin : cen_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk); #1;
      div = (div + 1) % 4;
      cen = (div == 0);
    end
  end

  // Decoder model.
  logic [7:0] din_log[$];
  int         wid_log[$];
  int         lvl_log[$];
  int         play_ticks = 100;
  bit         model_en   = 1'b1;
  int         stn_viol   = 0;

  initial begin : busy_model
    int st, cnt, w;
    st = 0; cnt = 0; w = 0;
    forever begin
      @(posedge clk); #2;
      if (snd_rst) begin
        st = 0;
        snd_busyn = 1'b1;
      end else begin
        case (st)
          0: if (!snd_stn) begin
               din_log.push_back(snd_din);
               lvl_log.push_back(int'(q_level));
               w  = cen ? 1 : 0;
               st = 1;
             end
          1: if (snd_stn) begin
               wid_log.push_back(w);
               st = 2;
             end else if (cen) w++;
          2: begin
               if (!snd_stn) stn_viol++;
               if (cen) begin
                 if (model_en) begin
                   snd_busyn = 1'b0;
                   cnt = 0;
                   st  = 3;
                 end else st = 0;
               end
             end
          default: begin
               if (!snd_stn) stn_viol++;
               if (cen) begin
                 cnt++;
                 if (cnt == play_ticks) begin
                   snd_busyn = 1'b1;
                   st = 0;
                 end
               end
             end
        endcase
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not end within 3 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic cen_tick();
    while (!cen) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] p);
    req_we = 1'b1;
    req_phrase = p;
    @(negedge clk);
    req_we = 1'b0;
  endtask

  task automatic wait_busyn(input logic v, input string name);
    int t;
    t = 0;
    while (snd_busyn !== v && t < 5000) begin @(negedge clk); t++; end
    if (snd_busyn !== v) expire(name);
  endtask

  task automatic wait_stn(input logic v, input string name);
    int t;
    t = 0;
    while (snd_stn !== v && t < 5000) begin @(negedge clk); t++; end
    if (snd_stn !== v) expire(name);
  endtask

  task automatic wait_log(input int n, input string name);
    int t;
    t = 0;
    while (wid_log.size() < n && t < 20000) begin @(negedge clk); t++; end
    if (wid_log.size() < n) expire(name);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(active === 1'b0 && snd_busyn === 1'b1) && t < 20000) begin @(negedge clk); t++; end
    if (active !== 1'b0) expire(name);
  endtask

  task automatic wait_rst_low(input string name);
    int t;
    t = 0;
    while (snd_rst !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
    if (snd_rst !== 1'b0) expire(name);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] phrase;
    logic       stop;
    logic [2:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  initial begin : main
    vec_t vecs[6];
    int   n0, cyc, cnt, t;

    // Queue filling while phrase 0x21 plays: four fit, the fifth is dropped.
    vecs[0] = '{1'b1, 8'h22, 1'b0, 3'd1, 1'b0};
    vecs[1] = '{1'b1, 8'h23, 1'b0, 3'd2, 1'b0};
    vecs[2] = '{1'b1, 8'h24, 1'b0, 3'd3, 1'b0};
    vecs[3] = '{1'b1, 8'h25, 1'b0, 3'd4, 1'b0};
    vecs[4] = '{1'b1, 8'h26, 1'b0, 3'd4, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_q_level", q_level, 0);
    check("rst_stn", snd_stn, 1);
    check("rst_cs", snd_cs, 0);
    check("rst_din", snd_din, 0);
    check("rst_mdn", snd_mdn, 1);
    check("rst_snd_rst", snd_rst, 1);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    check("rst_active", active, 0);
    rst = 1'b0;
    @(negedge clk);
    check("snd_rst_release", snd_rst, 0);
    repeat (3) @(negedge clk);

    // Single phrase 0x05
    push(8'h05);
    cyc = 1;
    while (snd_stn && cyc < 50) begin @(negedge clk); cyc++; end
    check("push_to_stn_latency_ok", (cyc >= 6 && cyc <= 9), 1);
    check("p05_din", snd_din, 8'h05);
    check("p05_cs", snd_cs, 1);
    wait_log(1, "p05_start");
    check("p05_log_din", din_log[0], 8'h05);
    check("p05_stn_width", wid_log[0], STW);
    wait_busyn(1'b0, "p05_busy_low");
    wait_busyn(1'b1, "p05_busy_high");
    cen_tick();
    check("p05_active_in_gap", active, 1);
    cen_tick();
    check("p05_active_drop", active, 0);

    // Three back-to-back pushes
    cen_tick();
    n0 = wid_log.size();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("burst_level3", q_level, 3);
    wait_log(n0 + 3, "burst_starts");
    wait_idle("burst_idle");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("burst_din%0d", k), din_log[n0 + k], 8'(k + 1));
      check($sformatf("burst_lvl%0d", k), lvl_log[n0 + k], 2 - k);
      check($sformatf("burst_wid%0d", k), wid_log[n0 + k], STW);
    end
    check("burst_count", wid_log.size(), n0 + 3);
    check("stn_during_busy", stn_viol, 0);

    // Overflow while playing
    n0 = wid_log.size();
    push(8'h21);
    wait_busyn(1'b0, "ovf_first_busy");
    for (int i = 0; i < 6; i++) begin
      req_we = vecs[i].we;
      req_phrase = vecs[i].phrase;
      req_stop = vecs[i].stop;
      @(negedge clk);
      req_we = 1'b0;
      req_stop = 1'b0;
      check($sformatf("vec%0d_level", i), q_level, vecs[i].exp_level);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
    end
    wait_log(n0 + 5, "ovf_starts");
    wait_idle("ovf_idle");
    for (int k = 0; k < 5; k++)
      check($sformatf("ovf_din%0d", k), din_log[n0 + k], 8'(8'h21 + k));
    check("ovf_count", wid_log.size(), n0 + 5);

    // Stop during PLAY with two entries queued
    n0 = wid_log.size();
    push(8'h31);
    wait_busyn(1'b0, "stop_busy");
    push(8'h32);
    push(8'h33);
    check("stop_pre_level", q_level, 2);
    req_stop = 1'b1;
    @(negedge clk);
    req_stop = 1'b0;
    check("stop_level0", q_level, 0);
    check("stop_snd_rst", snd_rst, 1);
    check("stop_stn_high", snd_stn, 1);
    cnt = 0; t = 0;
    while (snd_rst && t < 100) begin
      if (cen) cnt++;
      @(negedge clk);
      t++;
    end
    check("stop_rst_ticks", cnt, 4);
    check("stop_active_after", active, 0);
    repeat (20) cen_tick();
    check("stop_no_more_stn", din_log.size(), n0 + 1);
    check("stop_level_after", q_level, 0);

    // Stop and push in the same cycle
    n0 = din_log.size();
    req_we = 1'b1;
    req_phrase = 8'h44;
    req_stop = 1'b1;
    @(negedge clk);
    req_we = 1'b0;
    req_stop = 1'b0;
    check("stopwe_level", q_level, 0);
    wait_rst_low("stopwe_rst");
    repeat (20) cen_tick();
    check("stopwe_level_after", q_level, 0);
    check("stopwe_no_stn", din_log.size(), n0);
    check("stopwe_active", active, 0);

`ifdef JT7759_SEQ_TIMEOUT_EN
    // Busy timeout: busyn never goes low
    model_en = 1'b0;
    n0 = wid_log.size();
    push(8'h51);
    push(8'h52);
    wait_stn(1'b0, "tmo_stn_low");
    wait_stn(1'b1, "tmo_stn_high");
    repeat (254) cen_tick();
    check("tmo_err_before", err, 0);
    cen_tick();
    check("tmo_err_set", err, 1);
    wait_log(n0 + 2, "tmo_next_start");
    check("tmo_next_din", din_log[n0 + 1], 8'h52);
    check("tmo_err_sticky", err, 1);
    push(8'h53);
    check("tmo_err_clear", err, 0);
    req_stop = 1'b1;
    @(negedge clk);
    req_stop = 1'b0;
    wait_rst_low("tmo_stop");
    check("tmo_level_after", q_level, 0);
    model_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
